// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the DSP48A1 MAC sequencer.
package dsp_mac_pkg;

    localparam int A_W = 18;
    localparam int B_W = 18;
    localparam int P_W = 48;

    // X=M, Z=0: first product of a frame overwrites P
    localparam logic [7:0] OPM_MUL = 8'h01;
    // X=M, Z=P, add: later products accumulate into P
    localparam logic [7:0] OPM_MAC = 8'h09;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } state_t;

    // One delay-line slot: a real sample (vld) and whether it opens the frame
    typedef struct packed {
        logic vld;
        logic first;
    } pipe_ent_t;

    // OPMODE for the sample sitting in a slot; bubbles drive 0
    function automatic logic [7:0] opm_sel(input pipe_ent_t e);
        if (!e.vld) return 8'h00;
        return e.first ? OPM_MUL : OPM_MAC;
    endfunction

endpackage

// File: rtl/dsp_mac_sequencer_valid_pipe.sv
// Delay line that shadows the slice pipeline. Slot 0 is the current-cycle
// fire (combinational); slots 1..MAC_LAT-1 are registered, so slot k holds
// the sample that fired k cycles ago.
module dsp_valid_pipe
    import dsp_mac_pkg::*;
#(
    parameter int MAC_LAT = 3,
    parameter int OP_LEAD = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  pipe_ent_t din,
    output pipe_ent_t opm_tap,
    output pipe_ent_t p_tap,
    output logic      empty
);

    pipe_ent_t [MAC_LAT-1:0] tap;
    pipe_ent_t [MAC_LAT-1:1] pipe_q;
    pipe_ent_t [MAC_LAT-1:1] pipe_d;

    // Shift by one slot every cycle; a non-fire cycle shifts in a bubble
    always_comb begin
        pipe_d[1] = din;
        for (int k = 2; k < MAC_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    // Flatten input and registered slots into one tap view; flag empty
    always_comb begin
        tap[0] = din;
        empty  = 1'b1;
        for (int k = 1; k < MAC_LAT; k++) begin
            tap[k] = pipe_q[k];
            if (pipe_q[k].vld) empty = 1'b0;
        end
    end

    assign opm_tap = tap[MAC_LAT-1-OP_LEAD];
    assign p_tap   = tap[MAC_LAT-1];

    // Delay-line registers, cleared asynchronously so in-flight samples vanish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Frame-based multiply-accumulate controller for a DSP48A1 slice
// (A1REG=B1REG=MREG=PREG=OPMODEREG=1, A0REG=B0REG=0).
module dsp_mac_sequencer
    import dsp_mac_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 3,
    parameter int OP_LEAD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [A_W-1:0]   s_a,
    input  logic [B_W-1:0]   s_b,
    output logic [A_W-1:0]   dsp_a,
    output logic [B_W-1:0]   dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_ceopmode,
    output logic             dsp_cep,
    output logic             dsp_rstp,
    input  logic [P_W-1:0]   dsp_p,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [P_W-1:0]   m_result
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             busy_q, busy_d;
    logic             m_valid_q, m_valid_d;
    logic [P_W-1:0]   m_result_q, m_result_d;

    logic             start_acc;
    logic             fire;
    pipe_ent_t        pipe_in;
    pipe_ent_t        opm_tap;
    pipe_ent_t        p_tap;
    logic             pipe_empty;

    assign start_acc = (state_q == IDLE) && start;
    assign s_ready   = (state_q == RUN) && (cnt_q < len_q);
    assign fire      = s_valid && s_ready;

    // Only real samples enter the delay line; bubbles keep the first flag
    assign pipe_in.vld   = fire;
    assign pipe_in.first = fire && first_q;

    dsp_valid_pipe #(
        .MAC_LAT (MAC_LAT),
        .OP_LEAD (OP_LEAD)
    ) u_vpipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (pipe_in),
        .opm_tap (opm_tap),
        .p_tap   (p_tap),
        .empty   (pipe_empty)
    );

    // Next-state and output-register logic for the frame FSM
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        busy_d     = busy_q;
        m_valid_d  = m_valid_q;
        m_result_d = m_result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = cfg_len;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    busy_d  = 1'b1;
                    if (cfg_len == '0) begin
                        state_d    = OUT;
                        m_result_d = '0;
                        m_valid_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (fire) begin
                    cnt_d   = cnt_q + ONE;
                    first_d = 1'b0;
                    if (cnt_q + ONE == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Empty means the last P edge happened at the end of last cycle
                if (pipe_empty) begin
                    m_result_d = dsp_p;
                    m_valid_d  = 1'b1;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            busy_q     <= 1'b0;
            m_valid_q  <= 1'b0;
            m_result_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            busy_q     <= busy_d;
            m_valid_q  <= m_valid_d;
            m_result_q <= m_result_d;
        end
    end

    assign busy     = busy_q;
    assign m_valid  = m_valid_q;
    assign m_result = m_result_q;

    assign dsp_a        = s_a;
    assign dsp_b        = s_b;
    assign dsp_cea      = busy_q;
    assign dsp_ceb      = busy_q;
    assign dsp_cem      = busy_q;
    assign dsp_ceopmode = busy_q;
    assign dsp_opmode   = opm_sel(opm_tap);
    assign dsp_cep      = p_tap.vld;
    // Held during reset so the slice P is flushed along with the controller
    assign dsp_rstp     = !rst_n || start_acc;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice.
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_len;
    logic        busy;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_a, s_b;
    logic [17:0] dsp_a, dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rstp;
    logic [47:0] dsp_p;
    logic        m_valid;
    logic        m_ready;
    logic [47:0] m_result;

    always #5 clk = ~clk;

    dsp_mac_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .busy(busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
        .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem),
        .dsp_ceopmode(dsp_ceopmode), .dsp_cep(dsp_cep), .dsp_rstp(dsp_rstp),
        .dsp_p(dsp_p), .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result)
    );

    // Slice model: A1/B1 -> M -> P, OPMODE register, synchronous RSTP
    logic signed [17:0] a1_q, b1_q;
    logic signed [35:0] m_q;
    logic [7:0]         opm_q;
    logic [47:0]        p_q;
    logic [47:0]        xmux, zmux;
    assign xmux  = (opm_q[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'd0;
    assign zmux  = (opm_q[3:2] == 2'b10) ? p_q : 48'd0;
    assign dsp_p = p_q;
    always @(posedge clk) begin
        if (dsp_cea) a1_q <= dsp_a;
        if (dsp_ceb) b1_q <= dsp_b;
        if (dsp_cem) m_q <= a1_q * b1_q;
        if (dsp_ceopmode) opm_q <= dsp_opmode;
        if (dsp_rstp) p_q <= 48'd0;
        else if (dsp_cep) p_q <= zmux + xmux;
    end

    // Event counters sampled with pre-edge values
    int cep_cnt = 0, sready_cnt = 0, opm_n = 0, pchg = 0;
    logic [7:0]  opm_log [64];
    logic [47:0] p_seen;
    always @(posedge clk) begin
        if (dsp_cep) cep_cnt++;
        if (s_ready) sready_cnt++;
        if (dsp_opmode != 8'h00 && opm_n < 64) begin
            opm_log[opm_n] = dsp_opmode;
            opm_n++;
        end
        if (dsp_p !== p_seen) pchg++;
        p_seen = dsp_p;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] n);
        start   = 1'b1;
        cfg_len = n;
        @(negedge clk);
        start   = 1'b0;
        cfg_len = 8'hAA;
    endtask

    task automatic feed(input logic [17:0] a, input logic [17:0] b, inout int cyc);
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        for (int i = 0; i < 50 && !s_ready; i++) begin
            @(negedge clk);
            cyc++;
        end
        if (!s_ready) chk("fire_timeout", 64'(s_ready), 64'd1);
        @(negedge clk);
        cyc++;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n, inout int cyc);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_result(inout int cyc, output logic [47:0] res);
        for (int i = 0; i < 50 && !m_valid; i++) begin
            @(negedge clk);
            cyc++;
        end
        if (!m_valid) chk("result_timeout", 64'(m_valid), 64'd1);
        res = m_result;
    endtask

    task automatic take_result();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    logic [47:0] res;
    int cyc, snap, snap2;

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_len = 8'd0;
        s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sready", 64'(s_ready), 64'd0);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_opmode", 64'(dsp_opmode), 64'd0);
        chk("rst_cep", 64'(dsp_cep), 64'd0);
        chk("rst_rstp", 64'(dsp_rstp), 64'd1);
        chk("rst_mresult", 64'(m_result), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 4 samples, continuous valid: 2+12+30+56
        snap = opm_n;
        start_frame(8'd4); cyc = 1;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_cea", 64'(dsp_cea), 64'd1);
        feed(18'd1, 18'd2, cyc); feed(18'd3, 18'd4, cyc);
        feed(18'd5, 18'd6, cyc); feed(18'd7, 18'd8, cyc);
        wait_result(cyc, res);
        chk("t1_result", 64'(res), 64'd100);
        chk("t1_latency", 64'(cyc), 64'd8);
        chk("t1_opm_count", 64'(opm_n - snap), 64'd4);
        chk("t1_opm0", 64'(opm_log[snap]), 64'h01);
        chk("t1_opm1", 64'(opm_log[snap+1]), 64'h09);
        chk("t1_opm2", 64'(opm_log[snap+2]), 64'h09);
        chk("t1_opm3", 64'(opm_log[snap+3]), 64'h09);
        take_result();

        // 3 samples with 2-cycle bubbles: -6+20+1
        snap = cep_cnt; snap2 = pchg;
        start_frame(8'd3); cyc = 1;
        feed(-18'sd2, 18'd3, cyc); idle(2, cyc);
        feed(18'd4, 18'd5, cyc); idle(2, cyc);
        feed(-18'sd1, -18'sd1, cyc);
        wait_result(cyc, res);
        chk("t2_result", 64'(res), 64'd15);
        chk("t2_cep_cycles", 64'(cep_cnt - snap), 64'd3);
        // P changes: start flush 100->0, then -6, 14, 15 -- none in bubbles
        chk("t2_p_changes", 64'(pchg - snap2), 64'd4);
        take_result();

        // empty frame
        snap = sready_cnt;
        start_frame(8'd0); cyc = 1;
        chk("t3_mvalid_next", 64'(m_valid), 64'd1);
        chk("t3_result", 64'(m_result), 64'd0);
        wait_result(cyc, res);
        chk("t3_sready_never", 64'(sready_cnt - snap), 64'd0);
        take_result();

        // result held under backpressure: 6+20, start during hold ignored
        start_frame(8'd2); cyc = 1;
        feed(18'd2, 18'd3, cyc); feed(18'd4, 18'd5, cyc);
        wait_result(cyc, res);
        chk("t4_result", 64'(res), 64'd26);
        for (int i = 0; i < 5; i++) begin
            start   = (i == 2);
            cfg_len = 8'd1;
            @(negedge clk);
            start = 1'b0;
            chk("t4_hold_result", 64'(m_result), 64'd26);
            chk("t4_hold_busy", 64'(busy), 64'd1);
            chk("t4_hold_mvalid", 64'(m_valid), 64'd1);
        end
        take_result();
        chk("t4_idle_busy", 64'(busy), 64'd0);
        chk("t4_idle_mvalid", 64'(m_valid), 64'd0);
        start_frame(8'd1); cyc = 1;
        feed(18'd9, 18'd9, cyc);
        wait_result(cyc, res);
        chk("t4_result2", 64'(res), 64'd81);
        chk("t4_latency2", 64'(cyc), 64'd5);
        take_result();

        // asynchronous reset mid-RUN after 2 of 4 samples
        start_frame(8'd4); cyc = 1;
        feed(18'd5, 18'd5, cyc); feed(18'd6, 18'd6, cyc);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_sready", 64'(s_ready), 64'd0);
        chk("t5_mvalid", 64'(m_valid), 64'd0);
        chk("t5_cea", 64'(dsp_cea), 64'd0);
        chk("t5_cep", 64'(dsp_cep), 64'd0);
        chk("t5_opmode", 64'(dsp_opmode), 64'd0);
        chk("t5_mresult", 64'(m_result), 64'd0);
        chk("t5_rstp", 64'(dsp_rstp), 64'd1);
        repeat (2) @(negedge clk);
        chk("t5_rstp_held", 64'(dsp_rstp), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        start_frame(8'd2); cyc = 1;
        feed(18'd1, 18'd1, cyc); feed(18'd1, 18'd1, cyc);
        wait_result(cyc, res);
        chk("t5_result", 64'(res), 64'd2);
        take_result();

        // full-scale products, then a fresh frame must not carry residue
        start_frame(8'd2); cyc = 1;
        feed(18'd131071, 18'd131071, cyc); feed(18'd131071, 18'd131071, cyc);
        wait_result(cyc, res);
        chk("t6_result_big", 64'(res), 64'd34359214082);
        take_result();
        start_frame(8'd1); cyc = 1;
        feed(18'd1, 18'd1, cyc);
        wait_result(cyc, res);
        chk("t6_result_one", 64'(res), 64'd1);
        take_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
